// File: rtl/arbitro_decodificador.sv
// -----------------------------------------------------------------------------
// arbitro_decodificador
//
// Round-robin arbiter that owns the address/enable inputs of a shared 3-to-8
// decoder. Eight requesters hold req[i] high until they are done. The current
// grantee index is registered and drives the decoder address. The enable is
// high only while a grant is active. After every release there is one
// break-before-make cycle with the enable low. Then a new arbitration starts
// from the requester just after the previous owner.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   defined   - a grant is forcibly released after MAX_CICLOS cycles while
//               its request is still high. estouro pulses for that release.
//   undefined - a grant is held for as long as req[a] stays high, and
//               estouro is tied low.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [N_REQ-1:0] request vector
//   a        out  [2:0] decoder address (index of current/last grantee)
//   en       out  decoder enable, high only while a grant is active
//   gnt      out  [N_REQ-1:0] one-hot grant, mirrors the decoder output
//   ocupado  out  high whenever the arbiter is not idle
//   estouro  out  one-cycle pulse on a timeout release
// -----------------------------------------------------------------------------
module arbitro_decodificador #(
    parameter int N_REQ      = 8,   // fixed at 8 to match the 3-bit address
    parameter int MAX_CICLOS = 16   // grant hold limit, 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [2:0]       a,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             ocupado,
    output logic             estouro
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CONCEDE = 2'd1,
        LIBERA  = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [2:0] a_q, a_d;
    logic [2:0] ptr_q, ptr_d;

    logic       achou;
    logic [2:0] escolha;
    logic [2:0] idx;

    // Circular search starting at ptr. The first set bit wins. The 3-bit add
    // gives the 7 -> 0 wrap for free.
    always_comb begin
        achou   = 1'b0;
        escolha = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!achou && req[idx]) begin
                achou   = 1'b1;
                escolha = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_LIM = 8'(MAX_CICLOS - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       estouro_q, estouro_d;
`else
    // MAX_CICLOS only matters when the timeout is built in.
    logic unused_cfg;
    assign unused_cfg = (MAX_CICLOS > 0);
`endif

    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        ptr_d    = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        estouro_d = 1'b0;
`endif
        unique case (estado_q)
            OCIOSO: begin
                if (achou) begin
                    a_d      = escolha;
                    estado_d = CONCEDE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = 8'd0;
`endif
                end
            end
            CONCEDE: begin
`ifdef ARB_TIMEOUT_EN
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                // A normal release takes precedence over a timeout on the same edge.
                if (!req[a_q]) begin
                    estado_d = LIBERA;
                    ptr_d    = a_q + 3'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q >= CNT_LIM) begin
                    estado_d  = LIBERA;
                    ptr_d     = a_q + 3'd1;
                    estouro_d = 1'b1;
                end
`endif
            end
            LIBERA: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            a_q      <= 3'd0;
            ptr_q    <= 3'd0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            estouro_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            estouro_q <= estouro_d;
        end
    end

    assign estouro = estouro_q;
`else
    assign estouro = 1'b0;
`endif

    // Outputs come only from registered state, so they cannot glitch. Reset
    // clears the state register asynchronously, which drops en/gnt at once.
    assign a       = a_q;
    assign en      = (estado_q == CONCEDE);
    assign gnt     = en ? (N_REQ'(1) << a_q) : '0;
    assign ocupado = (estado_q != OCIOSO);

endmodule

// File: tb/tb_arbitro_decodificador.sv
// -----------------------------------------------------------------------------
// tb_arbitro_decodificador
//
// Directed testbench for arbitro_decodificador. A behavioural model tracks
// owner, pointer, hold time and the break-before-make gap, and every output is
// compared against it on each falling clock edge. Literal expectations at key
// points pin the model. The timeout scenario follows ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_arbitro_decodificador;

    localparam int MAXC = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [2:0] a;
    logic       en;
    logic [7:0] gnt;
    logic       ocupado;
    logic       estouro;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    bit rec_on   = 1'b0;
    bit en_prev  = 1'b0;
    int order[$];

    arbitro_decodificador #(.N_REQ(8), .MAX_CICLOS(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a(a), .en(en),
        .gnt(gnt), .ocupado(ocupado), .estouro(estouro)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit granted;   // a grant is active this cycle
        bit gap;       // first idle cycle right after a release
        int owner;     // last granted requester
        int ptr;       // requester with highest priority next time
        int held;      // cycles the current grant has been active
        bit est;       // this gap cycle came from a timeout
    } mod_t;

    mod_t m;

    function automatic mod_t mod_reset();
        mod_t s;
        s.granted = 0; s.gap = 0; s.owner = 0; s.ptr = 0; s.held = 0; s.est = 0;
        return s;
    endfunction

    function automatic mod_t mod_next(mod_t s, logic [7:0] r);
        mod_t n;
        bit found;
        n = s;
        n.est = 0;
        found = 0;
        if (s.granted) begin
            if (r[s.owner] == 1'b0) begin
                n.granted = 0; n.gap = 1; n.ptr = (s.owner + 1) % 8;
            end
`ifdef ARB_TIMEOUT_EN
            else if (s.held >= MAXC) begin
                n.granted = 0; n.gap = 1; n.ptr = (s.owner + 1) % 8; n.est = 1;
            end
`endif
            else begin
                n.held = s.held + 1;
            end
        end else if (s.gap) begin
            n.gap = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (s.ptr + k) % 8;
                if (!found && r[i]) begin
                    found = 1; n.granted = 1; n.owner = i; n.held = 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mod_reset();
        else        m <= mod_next(m, req);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_a",       32'(a),       32'(m.owner));
            chk("model_en",      32'(en),      32'(m.granted));
            chk("model_gnt",     32'(gnt),     m.granted ? (32'd1 << m.owner) : 32'd0);
            chk("model_ocupado", 32'(ocupado), 32'(m.granted | m.gap));
            chk("model_estouro", 32'(estouro), 32'(m.est));
            if (rec_on && en && !en_prev) order.push_back(int'(a));
        end
        en_prev <= en;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int exp_order[9];
        exp_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        // Reset with every requester active.
        #1;
        rst_n  = 1'b0;
        req    = 8'hFF;
        chk_on = 1'b1;
        cyc(2);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'h00);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_estouro", 32'(estouro), 32'd0);
        rst_n = 1'b1;
        cyc(1);
        chk("first_en", 32'(en), 32'd1);
        chk("first_a", 32'(a), 32'd0);
        chk("first_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        cyc(2);

        // Single requester held for 3 cycles.
        req = 8'h20;
        cyc(1);
        chk("single_a", 32'(a), 32'd5);
        chk("single_gnt", 32'(gnt), 32'h20);
        cyc(2);
        chk("single_gnt3", 32'(gnt), 32'h20);
        req = 8'h00;
        cyc(1);
        chk("single_lib_en", 32'(en), 32'd0);
        chk("single_lib_ocup", 32'(ocupado), 32'd1);
        cyc(1);
        chk("single_idle_en", 32'(en), 32'd0);
        chk("single_idle_ocup", 32'(ocupado), 32'd0);

        // Rotation with all requesting; each owner drops for one cycle.
        rst_n = 1'b0;
        req   = 8'hFF;
        #2;
        rst_n = 1'b1;
        order.delete();
        rec_on = 1'b1;
        for (int g = 0; g < 9; g++) begin
            for (int t = 0; t < 20 && en !== 1'b1; t++) cyc(1);
            chk("rot_grant_seen", 32'(en), 32'd1);
            cyc(1);
            req = 8'hFF & ~(8'h01 << a);
            cyc(1);
            req = (g == 8) ? 8'h00 : 8'hFF;
        end
        rec_on = 1'b0;
        chk("rot_count", 32'(order.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk("rot_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end
        cyc(1);

        // Wrap-around: owner 7, then 0 wins over 7 after ptr wraps.
        req = 8'h80;
        cyc(1);
        chk("wrap_a7", 32'(a), 32'd7);
        req = 8'h00;
        cyc(1);
        req = 8'h81;
        cyc(2);
        chk("wrap_a0", 32'(a), 32'd0);
        chk("wrap_gnt", 32'(gnt), 32'h01);

        // Asynchronous reset in the middle of a grant to requester 3.
        req = 8'h00;
        cyc(2);
        req = 8'h08;
        cyc(1);
        chk("async_pre_a", 32'(a), 32'd3);
        chk("async_pre_en", 32'(en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_en", 32'(en), 32'd0);
        chk("async_gnt", 32'(gnt), 32'h00);
        chk("async_a", 32'(a), 32'd0);
        chk("async_ocup", 32'(ocupado), 32'd0);
        req   = 8'h09;
        rst_n = 1'b1;
        cyc(1);
        chk("async_restart_a", 32'(a), 32'd0);
        chk("async_restart_gnt", 32'(gnt), 32'h01);

        // Long hold of requester 1 with requester 2 waiting.
        req = 8'h00;
        cyc(2);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 8'h06;
        cyc(1);
        chk("hold_a", 32'(a), 32'd1);
        chk("hold_en", 32'(en), 32'd1);
`ifdef ARB_TIMEOUT_EN
        cyc(3);
        chk("to_last_a", 32'(a), 32'd1);
        chk("to_last_est", 32'(estouro), 32'd0);
        cyc(1);
        chk("to_est", 32'(estouro), 32'd1);
        chk("to_en", 32'(en), 32'd0);
        cyc(1);
        chk("to_est_off", 32'(estouro), 32'd0);
        cyc(1);
        chk("to_next_a", 32'(a), 32'd2);
        chk("to_next_gnt", 32'(gnt), 32'h04);
`else
        cyc(20);
        chk("hold_long_a", 32'(a), 32'd1);
        chk("hold_long_en", 32'(en), 32'd1);
        chk("hold_long_est", 32'(estouro), 32'd0);
`endif
        req = 8'h00;
        cyc(3);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
